// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the PISO serializer.
// Holds the FSM state encoding and a clog2 helper used to size the bit counter.
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Ceiling log2, with a minimum result of 1 so a counter always has one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/piso_serializer_hold_buf.sv
// One-entry holding register that parks the next word while one is shifting.
// Ports: clock/reset, load_i/data_i write, clear_i drain, data_o/valid_o/ready_o.
module piso_hold_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             ready_o
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  // Ready comes straight from the flag so it never depends on data_valid.
  assign ready_o = !valid_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage feeding a serial-in shift register.
// Ports: clock, reset, data_in/data_valid/data_ready handshake,
//        serial_out/serial_enable stream, busy and word_done status.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             serial_enable,
  output logic             busy,
  output logic             word_done
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] hold_data;
  logic             hold_valid;
  logic             hold_load;
  logic             hold_clear;

  logic             xfer;
  logic             last;
  logic [WIDTH-1:0] shifted;

  piso_hold_buf #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clock  (clock),
    .reset  (reset),
    .load_i (hold_load),
    .data_i (data_in),
    .clear_i(hold_clear),
    .data_o (hold_data),
    .valid_o(hold_valid),
    .ready_o(data_ready)
  );

  assign xfer = data_valid && data_ready;
  assign last = (state_q == SHIFT) && (cnt_q == LAST);

  // Move toward the output bit, filling zeros behind the data.
  assign shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                             : {1'b0, shreg_q[WIDTH-1:1]};

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          shreg_d = data_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = shifted;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          cnt_d = '0;
          // Reload on the last-bit edge so streaming has no bubble.
          if (hold_valid) begin
            shreg_d    = hold_data;
            hold_clear = 1'b1;
          end else if (xfer) begin
            shreg_d = data_in;
          end else begin
            state_d = IDLE;
          end
        end else if (xfer) begin
          hold_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign serial_enable = (state_q == SHIFT);
  assign serial_out    = serial_enable &&
                         (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
  assign word_done     = last;
  assign busy          = (state_q == SHIFT) || hold_valid;

endmodule

// File: tb/tb_piso_serializer.sv
// Randomized bench for piso_serializer (MSB-first and LSB-first instances).
// A word-queue model predicts the serial stream and handshake.
module tb_piso_serializer;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         data_valid = 1'b0;

  logic m_ready, m_so, m_en, m_busy, m_done;
  logic l_ready, l_so, l_en, l_busy, l_done;

  logic [W-1:0] q;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] mq[$];
  int           pos = 0;
  logic         q_chk = 1'b0;
  logic [W-1:0] exp_q = '0;

  always #5 clock = ~clock;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clock        (clock),
    .reset        (reset),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (m_ready),
    .serial_out   (m_so),
    .serial_enable(m_en),
    .busy         (m_busy),
    .word_done    (m_done)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clock        (clock),
    .reset        (reset),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (l_ready),
    .serial_out   (l_so),
    .serial_enable(l_en),
    .busy         (l_busy),
    .word_done    (l_done)
  );

  // Downstream serial-in shift register fed by the MSB-first instance.
  always @(posedge clock) begin
    if (reset) q <= '0;
    else if (m_en) q <= {q[W-2:0], m_so};
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic v, input logic [W-1:0] d,
                            input logic r);
    logic acc;
    q_chk = 1'b0;
    if (r) begin
      mq.delete();
      pos = 0;
      return;
    end
    acc = v && (mq.size() < 2);
    if (mq.size() > 0) begin
      if (pos == W - 1) begin
        q_chk = 1'b1;
        exp_q = mq[0];
        void'(mq.pop_front());
        pos = 0;
      end else begin
        pos++;
      end
    end
    if (acc) mq.push_back(d);
  endtask

  task automatic check_outputs();
    logic         act;
    logic [W-1:0] w;
    act = (mq.size() > 0);
    w   = act ? mq[0] : '0;
    chk("m_ready", m_ready, mq.size() < 2);
    chk("l_ready", l_ready, mq.size() < 2);
    chk("m_en", m_en, act);
    chk("l_en", l_en, act);
    chk("m_busy", m_busy, act);
    chk("l_busy", l_busy, act);
    chk("m_done", m_done, act && pos == W - 1);
    chk("l_done", l_done, act && pos == W - 1);
    chk("m_so", m_so, act ? w[W-1-pos] : 1'b0);
    chk("l_so", l_so, act ? w[pos] : 1'b0);
    if (q_chk) chk("sipo_q", q, exp_q);
  endtask

  task automatic tick(input logic v, input logic [W-1:0] d,
                      input logic r);
    data_valid = v;
    data_in    = d;
    reset      = r;
    @(posedge clock);
    model_edge(v, d, r);
    @(negedge clock);
    check_outputs();
  endtask

  initial begin
    tick(1'b0, 4'h0, 1'b1);
    tick(1'b1, 4'hf, 1'b1);
    tick(1'b0, 4'h0, 1'b0);

    tick(1'b1, 4'b1011, 1'b0);
    repeat (5) tick(1'b0, 4'h0, 1'b0);

    tick(1'b1, 4'b1100, 1'b0);
    tick(1'b1, 4'b0011, 1'b0);
    repeat (8) tick(1'b0, 4'h0, 1'b0);

    tick(1'b1, 4'b0110, 1'b0);
    repeat (3) tick(1'b0, 4'h0, 1'b0);
    tick(1'b1, 4'b1001, 1'b0);
    repeat (5) tick(1'b0, 4'h0, 1'b0);

    tick(1'b1, 4'b1111, 1'b0);
    tick(1'b1, 4'b0101, 1'b0);
    tick(1'b1, 4'b0000, 1'b1);
    repeat (4) tick(1'b0, 4'h0, 1'b0);

    tick(1'b1, 4'b0001, 1'b0);
    repeat (5) tick(1'b0, 4'h0, 1'b0);

    tick(1'b1, 4'b1010, 1'b0);
    tick(1'b1, 4'b0110, 1'b0);
    repeat (6) tick(1'b1, W'($urandom_range(0, 15)), 1'b0);
    repeat (8) tick(1'b0, 4'h0, 1'b0);

    repeat (800) begin
      tick($urandom_range(0, 9) < 6,
           W'($urandom_range(0, 15)),
           $urandom_range(0, 59) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
